// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one sram-like memory port between the inst (fetch) port
// and the data (LSU) port. The request path is combinational. A grant that is waiting
// on mem_addr_ok is locked until it is accepted. An owner FIFO records which port
// issued each accepted transaction, so that in-order responses are steered back to it.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternate the grant on ties).
module sram_req_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(OUTSTANDING - 1);

  // Owner FIFO entries: 0 = inst, 1 = data
  logic [OUTSTANDING-1:0] owner_fifo_r;
  logic [PW-1:0]          head_r;
  logic [PW-1:0]          tail_r;
  logic [CW-1:0]          count_r;
  logic                   lock_r;
  logic                   owner_r;
`ifdef ARB_ROUND_ROBIN_EN
  logic                   last_grant_r;
`endif

  logic grant_data_s;
  logic req_sel_s;
  logic full_s;
  logic empty_s;
  logic accept_s;
  logic pop_s;
  logic head_s;

  // Pointer increment that wraps modulo OUTSTANDING
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return {PW{1'b0}};
    end else begin
      return p + {{(PW-1){1'b0}}, 1'b1};
    end
  endfunction

  // Grant selection: a locked owner first, then tie-break, then whoever requests
  always_comb begin
    grant_data_s = 1'b0;
    if (lock_r) begin
      grant_data_s = owner_r;
    end else if (data_sram_req && inst_sram_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_data_s = ~last_grant_r;
`else
      grant_data_s = 1'b1;
`endif
    end else if (data_sram_req) begin
      grant_data_s = 1'b1;
    end else begin
      grant_data_s = 1'b0;
    end
  end

  assign req_sel_s = grant_data_s ? data_sram_req : inst_sram_req;
  assign full_s    = (count_r == FULL_CNT);
  assign empty_s   = (count_r == {CW{1'b0}});
  assign head_s    = owner_fifo_r[head_r];
  assign accept_s  = mem_req & mem_addr_ok;
  assign pop_s     = ~reset & mem_data_ok & ~empty_s;

  // Request path: mux the granted port onto the memory side; inst is a plain word read
  always_comb begin
    mem_req   = ~reset & ~full_s & req_sel_s;
    mem_wr    = 1'b0;
    mem_size  = 2'd2;
    mem_wstrb = 4'h0;
    mem_addr  = inst_sram_addr;
    mem_wdata = 32'h0000_0000;
    if (grant_data_s) begin
      mem_wr    = data_sram_wr;
      mem_size  = data_sram_size;
      mem_wstrb = data_sram_wstrb;
      mem_addr  = data_sram_addr;
      mem_wdata = data_sram_wdata;
    end else begin
      mem_addr  = inst_sram_addr;
    end
  end

  assign inst_sram_addr_ok = accept_s & ~grant_data_s;
  assign data_sram_addr_ok = accept_s & grant_data_s;
  assign inst_sram_data_ok = pop_s & ~head_s;
  assign data_sram_data_ok = pop_s & head_s;
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  // Lock, owner FIFO, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_fifo_r <= {OUTSTANDING{1'b0}};
      head_r       <= {PW{1'b0}};
      tail_r       <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      lock_r       <= 1'b0;
      owner_r      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_r <= 1'b0;
`endif
    end else begin
      if (mem_req && !mem_addr_ok) begin
        lock_r  <= 1'b1;
        owner_r <= grant_data_s;
      end else if (accept_s) begin
        lock_r  <= 1'b0;
      end else begin
        lock_r  <= lock_r;
      end
      if (accept_s) begin
        owner_fifo_r[tail_r] <= grant_data_s;
        tail_r               <= ptr_inc(tail_r);
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_r         <= grant_data_s;
`endif
      end else begin
        tail_r <= tail_r;
      end
      if (pop_s) begin
        head_r <= ptr_inc(head_r);
      end else begin
        head_r <= head_r;
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter with an owner scoreboard queue.
module tb_sram_req_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;
  bit exp_q[$];

  sram_req_arbiter #(.OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the expected owner and check steering of the current response (mem_data_ok high).
  task automatic resp_chk(input logic [31:0] rd);
    bit e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("inst_data_ok", {31'd0, inst_sram_data_ok}, {31'd0, ~e});
      chk("data_data_ok", {31'd0, data_sram_data_ok}, {31'd0, e});
      chk("rdata", e ? data_sram_rdata : inst_sram_rdata, rd);
    end
  endtask

  task automatic resp(input logic [31:0] rd);
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    #1;
    resp_chk(rd);
    tick();
    mem_data_ok = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    inst_sram_req = 1'b0; inst_sram_addr = 32'h0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0;
    data_sram_wstrb = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    tick();
    // Outputs gated while in reset
    inst_sram_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_inst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
    chk("rst_data_ok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
    tick();
    reset = 1'b0; inst_sram_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    #1;
    chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
    tick();

    // 1: single inst fetch
    inst_sram_req = 1'b1; inst_sram_addr = 32'hbfc0_0000; mem_addr_ok = 1'b1;
    #1;
    chk("t1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'hbfc0_0000);
    chk("t1_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("t1_mem_size", {30'd0, mem_size}, 32'd2);
    chk("t1_inst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    chk("t1_data_addr_ok", {31'd0, data_sram_addr_ok}, 32'd0);
    exp_q.push_back(1'b0);
    tick();
    inst_sram_req = 1'b0;
    tick();
    resp(32'h3c1d_0001);

    // 2: simultaneous requests, data first
    inst_sram_req = 1'b1; inst_sram_addr = 32'hbfc0_0004;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = 2'd2;
    data_sram_wstrb = 4'hf; data_sram_addr = 32'h0000_1000; data_sram_wdata = 32'h5555_aaaa;
    #1;
    chk("t2_data_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    chk("t2_inst_addr_ok0", {31'd0, inst_sram_addr_ok}, 32'd0);
    chk("t2_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("t2_mem_addr_d", mem_addr, 32'h0000_1000);
    chk("t2_mem_wdata", mem_wdata, 32'h5555_aaaa);
    chk("t2_mem_wstrb", {28'd0, mem_wstrb}, 32'hf);
    exp_q.push_back(1'b1);
    tick();
    data_sram_req = 1'b0;
    #1;
    chk("t2_inst_addr_ok1", {31'd0, inst_sram_addr_ok}, 32'd1);
    chk("t2_mem_addr_i", mem_addr, 32'hbfc0_0004);
    chk("t2_inst_forced", {mem_wr, mem_size, mem_wstrb, mem_wdata}, {1'b0, 2'd2, 4'h0, 32'h0});
    exp_q.push_back(1'b0);
    tick();
    inst_sram_req = 1'b0; mem_addr_ok = 1'b0;
    resp(32'haaaa_0001);
    resp(32'hbbbb_0002);

    // 3: data waits on addr_ok for 3 cycles with inst also requesting
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h0000_2000;
    inst_sram_req = 1'b1; inst_sram_addr = 32'hbfc0_0008;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_wait_addr", mem_addr, 32'h0000_2000);
      chk("t3_wait_oks", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd0);
      tick();
    end
    mem_addr_ok = 1'b1;
    #1;
    chk("t3_accept_oks", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd1);
    exp_q.push_back(1'b1);
    tick();
    data_sram_req = 1'b0; inst_sram_req = 1'b0; mem_addr_ok = 1'b0;
    resp(32'hcccc_0003);

    // 3b: inst locked, data arrives later but must wait
    inst_sram_req = 1'b1; inst_sram_addr = 32'hbfc0_000c;
    #1;
    chk("t3b_first", mem_addr, 32'hbfc0_000c);
    tick();
    data_sram_req = 1'b1;
    #1;
    chk("t3b_lock_addr", mem_addr, 32'hbfc0_000c);
    tick();
    mem_addr_ok = 1'b1;
    #1;
    chk("t3b_accept_oks", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd2);
    exp_q.push_back(1'b0);
    tick();
    inst_sram_req = 1'b0;
    #1;
    chk("t3b_data_next", {31'd0, data_sram_addr_ok}, 32'd1);
    exp_q.push_back(1'b1);
    tick();
    data_sram_req = 1'b0; mem_addr_ok = 1'b0;
    resp(32'hdddd_0004);
    resp(32'heeee_0005);

    // 4: FIFO full stall
    inst_sram_req = 1'b1; mem_addr_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      inst_sram_addr = 32'hbfc0_0100 + 32'(i * 4);
      #1;
      chk("t4_accept", {31'd0, inst_sram_addr_ok}, 32'd1);
      exp_q.push_back(1'b0);
      tick();
    end
    inst_sram_addr = 32'hbfc0_0108;
    #1;
    chk("t4_full_req", {31'd0, mem_req}, 32'd0);
    chk("t4_full_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'h1111_0001;
    #1;
    chk("t4_pop_cycle_req", {31'd0, mem_req}, 32'd0);
    resp_chk(32'h1111_0001);
    tick();
    mem_data_ok = 1'b0;
    #1;
    chk("t4_resume", {31'd0, inst_sram_addr_ok}, 32'd1);
    exp_q.push_back(1'b0);
    tick();
    inst_sram_req = 1'b0;
    resp(32'h1111_0002);
    resp(32'h1111_0003);

    // 5: reset with two outstanding discards them
    inst_sram_req = 1'b1;
    tick();
    tick();
    inst_sram_req = 1'b0; mem_addr_ok = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_data_ok = 1'b1;
      #1;
      chk("t5_no_data_ok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
      tick();
    end
    mem_data_ok = 1'b0;
    inst_sram_req = 1'b1; mem_addr_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t5_empty_accept", {31'd0, inst_sram_addr_ok}, 32'd1);
      exp_q.push_back(1'b0);
      tick();
    end
    inst_sram_req = 1'b0;
    resp(32'h2222_0001);
    resp(32'h2222_0002);

    // 6: both request continuously with a response every cycle after the first
    inst_sram_req = 1'b1; data_sram_req = 1'b1; mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit exp_d;
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (i % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      mem_data_ok = (i != 0); mem_rdata = 32'h3333_0000 + 32'(i);
      #1;
      chk("t6_grant", {30'd0, inst_sram_addr_ok, data_sram_addr_ok},
          {30'd0, ~exp_d, exp_d});
      if (i != 0) resp_chk(32'h3333_0000 + 32'(i));
      exp_q.push_back(exp_d);
      tick();
    end
    inst_sram_req = 1'b0; data_sram_req = 1'b0; mem_addr_ok = 1'b0;
    resp(32'h3333_0009);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
